// File: rtl/regfile_arbiter.sv
// regfile_arbiter
// Two-requester arbiter and sequencer for the 8 x 8 single-port register file.
// Each access is serialised as IDLE -> ACCESS -> RESP. Read data returns in a
// per-requester holding register, and the ack is a one-cycle pulse in RESP.
// Contention is resolved round-robin by default. Define
// REGFILE_ARB_FIXED_PRIO_EN to select fixed priority, where requester 0 always
// wins a tie and the last-winner tracking is removed.
module regfile_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [DW-1:0] rf_d,
  output logic [AW-1:0] rf_address,
  output logic          rf_we,
  input  logic [DW-1:0] rf_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    r_state;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_id;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_any_req;
  logic          w_grant1;
  logic          w_in_access;
  logic          w_in_resp;

  assign w_any_req   = req0 | req1;
  assign w_in_access = (r_state == S_ACCESS);
  assign w_in_resp   = (r_state == S_RESP);

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  // Requester 1 wins only when requester 0 is silent.
  assign w_grant1 = req1 & ~req0;
`else
  // Id of the most recent grant. It resets to 1 so requester 0 takes the first tie.
  logic r_last;

  // Requester 1 wins alone, or on a tie when requester 0 was granted last.
  assign w_grant1 = req1 & (~req0 | ~r_last);

  // Record the winner of every grant made in IDLE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last <= w_grant1;
    end
  end
`endif

  // Sequencer: take a request in IDLE, drive the register file for one cycle, then acknowledge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            // Latch the winner's command so later input changes are harmless.
            r_state <= S_ACCESS;
            r_id    <= w_grant1;
            r_we    <= w_grant1 ? we1    : we0;
            r_addr  <= w_grant1 ? addr1  : addr0;
            r_wdata <= w_grant1 ? wdata1 : wdata0;
          end
        end
        S_ACCESS: r_state <= S_RESP;
        S_RESP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Capture the register file's combinational read output at the end of a read ACCESS.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_in_access && !r_we) begin
      if (r_id) begin
        r_rdata1 <= rf_out;
      end else begin
        r_rdata0 <= rf_out;
      end
    end
  end

  // The address and data buses hold their latched values. The write strobe is
  // qualified to the ACCESS cycle only.
  assign rf_address = r_addr;
  assign rf_d       = r_wdata;
  assign rf_we      = w_in_access & r_we;

  assign ack0   = w_in_resp & ~r_id;
  assign ack1   = w_in_resp &  r_id;
  assign busy   = (r_state != S_IDLE);
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter.
// A behavioural register file sits on the rf_* port. Requests are issued in
// rounds. At the start of each round, a transaction-level model works out the
// grant order, the ack cycles and the read data. It pushes one expectation per
// transaction into a scoreboard. A monitor pops an entry on every ack.
`timescale 1ns/1ps
module tb_regfile_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, rf_we;
  logic [DW-1:0] rdata0, rdata1, rf_d, rf_out;
  logic [AW-1:0] rf_address;

  regfile_arbiter #(.DW(DW), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .rf_d(rf_d), .rf_address(rf_address), .rf_we(rf_we), .rf_out(rf_out)
  );

  always #5 clock = ~clock;

  // Behavioural single-port register file: combinational read, clocked write.
  logic [DW-1:0] rf_mem [8];
  assign rf_out = rf_mem[rf_address];
  always @(posedge clock) if (rf_we) rf_mem[rf_address] <= rf_d;

  logic [31:0] cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model state.
  logic [7:0] m_mem [8];
  logic [7:0] m_rd0, m_rd1;
  int         m_last;

  typedef struct packed {
    logic        id;
    logic        we;
    logic [2:0]  addr;
    logic [7:0]  wd;
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    logic [31:0] cyc;
  } exp_t;
  exp_t sbq[$];

  // Per-round transaction tables, indexed [requester][transaction].
  logic       tx_we   [2][8];
  logic [2:0] tx_addr [2][8];
  logic [7:0] tx_wd   [2][8];

  logic mon_en = 1'b0;
  int   we_cnt = 0;

  // Monitor: check write strobes against the in-flight entry and each ack against the scoreboard.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (rf_we) begin
        if (sbq.size() == 0) begin
          chk("rf_we_spurious", 32'(rf_we), 32'(0));
        end else begin
          chk("rf_we_on_read", 32'(rf_we), 32'(sbq[0].we));
          chk("rf_address", 32'(rf_address), 32'(sbq[0].addr));
          chk("rf_d", 32'(rf_d), 32'(sbq[0].wd));
          we_cnt++;
        end
      end
      if (ack0 || ack1) begin
        if (sbq.size() == 0) begin
          chk("ack_spurious", 32'({ack1, ack0}), 32'(0));
        end else begin
          e = sbq.pop_front();
          chk("ack_both", 32'(ack0 & ack1), 32'(0));
          chk("ack_id", 32'(ack1), 32'(e.id));
          chk("ack_cycle", cyc, e.cyc);
          chk("busy_in_resp", 32'(busy), 32'(1));
          chk("rdata0", 32'(rdata0), 32'(e.rd0));
          chk("rdata1", 32'(rdata1), 32'(e.rd1));
          chk("rf_we_count", 32'(we_cnt), 32'(e.we));
        end
        we_cnt = 0;
      end
    end
  end

  task automatic set_req(input int id, input logic r, input logic w,
                         input logic [2:0] a, input logic [7:0] d);
    if (id == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else         begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // One requester: present each transaction, wait for its ack, and drop or
  // replace the request at the edge that ends the ack cycle.
  task automatic drive(input int id, input int n);
    logic got;
    for (int i = 0; i < n; i++) begin
      set_req(id, 1'b1, tx_we[id][i], tx_addr[id][i], tx_wd[id][i]);
      got = 1'b0;
      for (int t = 0; t < 60 && !got; t++) begin
        @(negedge clock);
        got = (id == 0) ? ack0 : ack1;
      end
      chk($sformatf("ack%0d_arrives", id), 32'(got), 32'(1));
      @(posedge clock); #1;
    end
    set_req(id, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
  endtask

  // Model the grant order of a round, push the expectations, then run both requesters.
  task automatic run_round(input int n0, input int n1);
    int r0, r1, k, w;
    logic [31:0] start;
    exp_t e;
    start = cyc;
    r0 = 0; r1 = 0; k = 0;
    while (r0 < n0 || r1 < n1) begin
      if (r0 < n0 && r1 < n1) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = 1 - m_last;
`endif
      end else begin
        w = (r0 < n0) ? 0 : 1;
      end
      m_last = w;
      e.id   = 1'(w);
      e.we   = tx_we[w][(w == 0) ? r0 : r1];
      e.addr = tx_addr[w][(w == 0) ? r0 : r1];
      e.wd   = tx_wd[w][(w == 0) ? r0 : r1];
      if (e.we) m_mem[e.addr] = e.wd;
      else if (w == 0) m_rd0 = m_mem[e.addr];
      else m_rd1 = m_mem[e.addr];
      e.rd0 = m_rd0;
      e.rd1 = m_rd1;
      e.cyc = start + 32'(2 + 3 * k);
      sbq.push_back(e);
      k++;
      if (w == 0) r0++; else r1++;
    end
    fork
      drive(0, n0);
      drive(1, n1);
    join
  endtask

  task automatic rand_tx(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      tx_we[id][i]   = 1'($urandom_range(0, 1));
      tx_addr[id][i] = 3'($urandom_range(0, 7));
      tx_wd[id][i]   = 8'($urandom);
    end
  endtask

  task automatic set_tx(input int id, input int i, input logic w,
                        input logic [2:0] a, input logic [7:0] d);
    tx_we[id][i] = w; tx_addr[id][i] = a; tx_wd[id][i] = d;
  endtask

  // Hold reset for two edges with random inputs and check the reset values after each edge.
  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req0 = 1'($urandom); req1 = 1'($urandom);
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = 3'($urandom); addr1 = 3'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      @(posedge clock);
      @(negedge clock);
      chk("rst_ack0", 32'(ack0), 32'(0));
      chk("rst_ack1", 32'(ack1), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_rf_we", 32'(rf_we), 32'(0));
      chk("rst_rdata0", 32'(rdata0), 32'(0));
      chk("rst_rdata1", 32'(rdata1), 32'(0));
      chk("rst_rf_address", 32'(rf_address), 32'(0));
      chk("rst_rf_d", 32'(rf_d), 32'(0));
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    m_last = 1; m_rd0 = 8'h00; m_rd1 = 8'h00;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    m_last = 1; m_rd0 = 8'h00; m_rd1 = 8'h00;
    do_reset();
    mon_en = 1'b1;

    // Fill every entry through the arbiter. Entries 1 and 2 get known values.
    for (int i = 0; i < 8; i++) set_tx(0, i, 1'b1, 3'(i), 8'($urandom));
    set_tx(0, 1, 1'b1, 3'd1, 8'h11);
    set_tx(0, 2, 1'b1, 3'd2, 8'h22);
    run_round(8, 0);

    // Reset leaves the register file intact and makes requester 0 win the first tie.
    do_reset();
    set_tx(0, 0, 1'b0, 3'd1, 8'h00);
    set_tx(1, 0, 1'b0, 3'd2, 8'h00);
    run_round(1, 1);

    // A requester 1 write must not disturb rdata0, which still holds 0x11.
    set_tx(1, 0, 1'b1, 3'd7, 8'h5C);
    run_round(0, 1);

    // Single write then read-back on requester 0.
    set_tx(0, 0, 1'b1, 3'd5, 8'hA3);
    run_round(1, 0);
    set_tx(0, 0, 1'b0, 3'd5, 8'h00);
    run_round(1, 0);
    set_tx(1, 0, 1'b0, 3'd7, 8'h00);
    run_round(0, 1);

    // Both requesters re-assert immediately after every ack.
    rand_tx(0, 4); rand_tx(1, 4);
    run_round(4, 4);

    // Requester 0 keeps re-asserting while requester 1 waits.
    rand_tx(0, 4); rand_tx(1, 1);
    run_round(4, 1);

    // A requester 1 read is aborted by a reset that lands on its ACCESS cycle.
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'($urandom_range(0, 7));
    @(posedge clock); #1;
    req1 = 1'b0;
    do_reset();
    set_tx(1, 0, 1'b0, 3'($urandom_range(0, 7)), 8'h00);
    run_round(0, 1);

    // Randomised rounds with random idle gaps between them.
    for (int r = 0; r < 25; r++) begin
      int a, b;
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      rand_tx(0, a); rand_tx(1, b);
      run_round(a, b);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(posedge clock); #1;
      end
    end

    repeat (4) @(posedge clock);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port arbiter and sequencer for the 8-entry × 8-bit single-port register file. Requester 0 (main control unit) and requester 1 (debug/load port) each issue one read or write at a time with a req/ack handshake. The arbiter serialises their accesses onto the register file's single address/data/write-enable port and returns read data in a per-requester register. By default it grants contending requests round-robin.

## Interface
Parameters:
- DW, 8, data width; matches register file word.
- AW, 3, address width; 8 entries.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0 / req1  in  1  access request, level; held until matching ack.
- we0 / we1  in  1  1 = write, 0 = read; valid while req high.
- addr0 / addr1  in  AW  register index.
- wdata0 / wdata1  in  DW  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DW  read result, held until next read by that requester.
- busy  out  1  high in ACCESS and RESP.
- rf_d  out  DW  to register file D.
- rf_address  out  AW  to register file address.
- rf_we  out  1  to register file write enable.
- rf_out  in  DW  register file combinational read output.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick a winner and latch its we/addr/wdata and its id into internal registers. Go to ACCESS. Otherwise stay in IDLE.
- Arbitration, round-robin (default):
  - A single request wins.
  - If both are high, the requester not recorded in last_winner wins.
  - last_winner updates on each grant.
- ACCESS:
  - rf_address = latched addr and rf_d = latched wdata.
  - rf_we = latched we, asserted only in this state.
  - On a read, rf_out is captured into rdata of the winner at the end of this cycle.
  - On a write, rdata is unchanged.
  - Go to RESP.
- RESP:
  - The winner's ack is high for exactly this cycle.
  - All req inputs are ignored.
  - Go to IDLE.
- Requester rule: req drops at the edge ending the ack cycle. A req still high in the following IDLE is a new transaction.
- Outside ACCESS: rf_we = 0, and rf_address/rf_d hold their last latched values.
- Inputs we/addr/wdata may change after the grant; only latched copies are used.

## Timing
- Latency: req high when sampled at edge k → ACCESS in cycle k+1 → ack in cycle k+2 → accept again at edge k+3. Throughput is one access per 3 cycles.
- rdata is valid in the same cycle as ack and remains stable afterwards.
- Reset (reset_n low at an edge) forces:
  - state = IDLE
  - ack0 = ack1 = 0
  - rf_we = 0
  - busy = 0
  - rdata0 = rdata1 = 0
  - latched addr/wdata/we = 0, so rf_address = 0 and rf_d = 0
  - last_winner = 1, so requester 0 wins the first tie
- Reset mid-operation: the in-flight transaction is aborted with no ack. If reset lands during ACCESS, that write completes on the same edge only if rf_we was already high; no further write follows.
- Contention with a pending loser: the loser's req stays high and is granted in the next IDLE, 3 cycles later. No starvation: round-robin bounds the wait to 3 cycles.
- Back-to-back requests from one requester with the other idle are each granted. Each needs req low for at least the RESP→IDLE edge per the requester rule.

## Configuration
- REGFILE_ARB_FIXED_PRIO_EN defined: fixed priority. Requester 0 always wins when both are high, and last_winner is unused. Requester 1 may starve under continuous req0.
- Undefined: round-robin as described under Operation.

## Test plan
- Reset: hold reset_n low 2 cycles with random inputs → all outputs 0, rf_we never high.
- Single write/read: req0 write addr 5 data 0xA3, then req0 read addr 5.
  - Write: rf_we high for exactly 1 cycle with rf_address=5 and rf_d=0xA3; ack0 2 cycles after req.
  - Read: rdata0=0xA3 with ack0.
- Tie after reset: req0 and req1 both high (reads of addr 1 and 2, preloaded 0x11 and 0x22) → ack0/rdata0=0x11 first, ack1/rdata1=0x22 three cycles later.
- Continuous contention: both reqs re-asserted immediately after each ack for 8 transactions → grants alternate 0,1,0,1…. With REGFILE_ARB_FIXED_PRIO_EN, ack1 never occurs while req0 is reasserted.
- Reset during ACCESS of a req1 read: no ack1 and rdata1=0; after release, a fresh req1 completes normally.
- Write isolation: req1 write addr 7 0x5C while rdata0 holds 0x11 → rdata0 stays 0x11, and a later read of addr 7 returns 0x5C.
